// File: rtl/ble_decoder.sv
// Bit-serial BLE-style link-layer decoder: oversampled bit strobe, access-address
// correlator, header/address/payload/CRC24 parser with sticky decoded-field outputs.
module ble_decoder #(
  parameter int          OSR         = 2,
  parameter logic [31:0] ACCESS_ADDR = 32'hD6BE898E,
  parameter logic [23:0] CRC_INIT    = 24'h555555
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rf_data_in,
  input  logic         rf_data_valid,
  output logic [47:0]  src_addr,
  output logic [47:0]  dst_addr,
  output logic [7:0]   packet_type,
  output logic [255:0] payload_data,
  output logic [7:0]   payload_length,
  output logic         packet_valid,
  output logic         crc_error,
  output logic [7:0]   debug_state,
  output logic [15:0]  debug_rssi
);

  localparam int              PH_W     = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(OSR - 1);
  localparam logic [23:0]     CRC_POLY = 24'h00065B;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HUNT = 3'd1,
    S_HDR  = 3'd2,
    S_ADDR = 3'd3,
    S_PAY  = 3'd4,
    S_CRC  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t state, state_nxt;

  function automatic logic [23:0] crc_step(input logic [23:0] c, input logic b);
    logic fb;
    fb = c[23] ^ b;
    return {c[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h000000);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [PH_W-1:0] phase_p0;
  logic            strobe_p0;
  logic            bit_p0;
  logic [30:0]     hunt_sr;
  logic [31:0]     hunt_win;
  logic            aa_hit;
  logic [7:0]      bit_cnt;
  logic [6:0]      hdr_sr;
  logic [7:0]      hdr_byte;
  logic [7:0]      pay_last;
  logic [23:0]     crc_reg;
  logic            crc_bad;
  logic            crc_ref;

  // Stage p0: phase counter and bit strobe on the last oversample of each air bit
  assign strobe_p0 = rf_data_valid && (phase_p0 == PH_LAST);
  assign bit_p0    = rf_data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      phase_p0 <= '0;
    else if (!rf_data_valid || phase_p0 == PH_LAST)
      phase_p0 <= '0;
    else
      phase_p0 <= phase_p0 + PH_W'(1);
  end

  // The window's bit 0 is only ever compared, so only bits [31:1] are stored
  assign hunt_win = {bit_p0, hunt_sr};
  assign aa_hit   = (state == S_HUNT) && strobe_p0 && (hunt_win == ACCESS_ADDR);
  assign hdr_byte = {bit_p0, hdr_sr};
  assign pay_last = {payload_length[4:0], 3'b000} - 8'd1;
  assign crc_ref  = crc_reg[5'd23 - bit_cnt[4:0]];

  assign debug_state = {5'b00000, state};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (rf_data_valid) state_nxt = S_HUNT;
      S_HUNT: begin
        if (!rf_data_valid)  state_nxt = S_IDLE;
        else if (aa_hit)     state_nxt = S_HDR;
      end
      S_HDR: begin
        if (!rf_data_valid)                   state_nxt = S_IDLE;
        else if (strobe_p0 && bit_cnt == 8'd7) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (!rf_data_valid)
          state_nxt = S_IDLE;
        else if (strobe_p0 && bit_cnt == 8'd47)
          state_nxt = (payload_length[4:0] != 5'd0) ? S_PAY : S_CRC;
      end
      S_PAY: begin
        if (!rf_data_valid)                        state_nxt = S_IDLE;
        else if (strobe_p0 && bit_cnt == pay_last) state_nxt = S_CRC;
      end
      S_CRC: begin
        if (!rf_data_valid)                    state_nxt = S_IDLE;
        else if (strobe_p0 && bit_cnt == 8'd23) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = rf_data_valid ? S_HUNT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: field capture, CRC accumulation and sticky outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hunt_sr        <= '0;
      bit_cnt        <= '0;
      hdr_sr         <= '0;
      crc_reg        <= '0;
      crc_bad        <= 1'b0;
      src_addr       <= '0;
      dst_addr       <= '0;
      packet_type    <= '0;
      payload_data   <= '0;
      payload_length <= '0;
      packet_valid   <= 1'b0;
      crc_error      <= 1'b0;
      debug_rssi     <= '0;
    end else begin
      if (state_nxt != state)
        bit_cnt <= '0;
      else if (strobe_p0)
        bit_cnt <= bit_cnt + 8'd1;

      if (aa_hit)
        debug_rssi <= '0;
      else if (strobe_p0)
        debug_rssi <= sat_inc(debug_rssi);

      case (state)
        S_IDLE: hunt_sr <= '0;
        S_HUNT: begin
          if (strobe_p0)
            hunt_sr <= aa_hit ? '0 : hunt_win[31:1];
          if (aa_hit) begin
            packet_valid <= 1'b0;
            crc_error    <= 1'b0;
            payload_data <= '0;
            crc_reg      <= CRC_INIT;
            crc_bad      <= 1'b0;
          end
        end
        S_HDR: begin
          if (strobe_p0) begin
            hdr_sr  <= hdr_byte[7:1];
            crc_reg <= crc_step(crc_reg, bit_p0);
            if (bit_cnt == 8'd7) begin
              packet_type    <= hdr_byte;
              payload_length <= {3'b000, hdr_byte[4:0]};
            end
          end
        end
        S_ADDR: begin
          if (strobe_p0) begin
            src_addr[bit_cnt[5:0]] <= bit_p0;
            crc_reg                <= crc_step(crc_reg, bit_p0);
          end
        end
        S_PAY: begin
          if (strobe_p0) begin
            payload_data[bit_cnt] <= bit_p0;
            crc_reg               <= crc_step(crc_reg, bit_p0);
          end
        end
        S_CRC: begin
          // Received CRC arrives MSB first; the computed CRC is frozen here
          if (strobe_p0 && (bit_p0 != crc_ref))
            crc_bad <= 1'b1;
        end
        S_DONE: begin
          packet_valid <= 1'b1;
          crc_error    <= crc_bad;
          dst_addr     <= '1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ble_decoder.sv
// Self-checking bench for ble_decoder: bit-position reference model compared every
// cycle, plus literal expectations for the directed packets.
module tb_ble_decoder;

  localparam int          OSR         = 2;
  localparam logic [31:0] ACCESS_ADDR = 32'hD6BE898E;
  localparam logic [23:0] CRC_INIT    = 24'h555555;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rf_data_in;
  logic         rf_data_valid;
  logic [47:0]  src_addr;
  logic [47:0]  dst_addr;
  logic [7:0]   packet_type;
  logic [255:0] payload_data;
  logic [7:0]   payload_length;
  logic         packet_valid;
  logic         crc_error;
  logic [7:0]   debug_state;
  logic [15:0]  debug_rssi;

  ble_decoder #(.OSR(OSR), .ACCESS_ADDR(ACCESS_ADDR), .CRC_INIT(CRC_INIT)) dut (
    .clk(clk), .rst_n(rst_n), .rf_data_in(rf_data_in), .rf_data_valid(rf_data_valid),
    .src_addr(src_addr), .dst_addr(dst_addr), .packet_type(packet_type),
    .payload_data(payload_data), .payload_length(payload_length),
    .packet_valid(packet_valid), .crc_error(crc_error),
    .debug_state(debug_state), .debug_rssi(debug_rssi)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_on  = 1'b0;
  bit saw_pay = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  function automatic logic [23:0] tb_crc(input logic [23:0] c, input logic b);
    logic [23:0] r;
    r = c << 1;
    if (c[23] ^ b) r = r ^ 24'h00065B;
    return r;
  endfunction

  // Reference model: mode 0 idle, 1 hunting, 2 inside a packet, 3 packet complete.
  // Inside a packet, m_pos is the index of the next bit after the access address.
  int           m_phase, m_mode, m_pos, m_len;
  logic [31:0]  m_win;
  logic [7:0]   m_hdr;
  logic [23:0]  m_crc;
  logic         m_err;
  logic [47:0]  m_src, m_dst;
  logic [7:0]   m_ptype, m_plen;
  logic [255:0] m_pay;
  logic         m_pv, m_ce;
  logic [15:0]  m_rssi;

  task automatic model_reset();
    m_phase = 0; m_mode = 0; m_pos = 0; m_len = 0; m_win = '0; m_hdr = '0;
    m_crc = '0; m_err = 1'b0; m_src = '0; m_dst = '0; m_ptype = '0; m_plen = '0;
    m_pay = '0; m_pv = 1'b0; m_ce = 1'b0; m_rssi = '0;
  endtask

  function automatic logic [7:0] m_state_code();
    if (m_mode == 0) return 8'd0;
    if (m_mode == 1) return 8'd1;
    if (m_mode == 3) return 8'd6;
    if (m_pos < 8)   return 8'd2;
    if (m_pos < 56)  return 8'd3;
    if (m_pos < 56 + 8 * m_len) return 8'd4;
    return 8'd5;
  endfunction

  task automatic model_step(input logic v, input logic d);
    logic        strobe, hit;
    logic [31:0] w;
    int          j;
    strobe  = v && (m_phase == OSR - 1);
    m_phase = !v ? 0 : ((m_phase == OSR - 1) ? 0 : m_phase + 1);
    hit = 1'b0;
    w   = {d, m_win[31:1]};
    if (m_mode == 1 && strobe) hit = (w == ACCESS_ADDR);
    if (strobe) m_rssi = hit ? 16'd0 : ((m_rssi == 16'hFFFF) ? m_rssi : m_rssi + 16'd1);
    case (m_mode)
      0: begin m_win = '0; if (v) m_mode = 1; end
      1: begin
        if (!v) m_mode = 0;
        else if (strobe) begin
          if (hit) begin
            m_win = '0; m_pv = 1'b0; m_ce = 1'b0; m_pay = '0;
            m_crc = CRC_INIT; m_err = 1'b0; m_pos = 0; m_mode = 2;
          end else m_win = w;
        end
      end
      2: begin
        if (!v) m_mode = 0;
        else if (strobe) begin
          if (m_pos < 8) begin
            m_hdr[m_pos] = d;
            m_crc = tb_crc(m_crc, d);
            if (m_pos == 7) begin
              m_ptype = m_hdr; m_len = int'(m_hdr[4:0]); m_plen = {3'b000, m_hdr[4:0]};
            end
          end else if (m_pos < 56) begin
            m_src[m_pos - 8] = d;
            m_crc = tb_crc(m_crc, d);
          end else if (m_pos < 56 + 8 * m_len) begin
            m_pay[m_pos - 56] = d;
            m_crc = tb_crc(m_crc, d);
          end else begin
            j = m_pos - 56 - 8 * m_len;
            if (d !== m_crc[23 - j]) m_err = 1'b1;
            if (j == 23) m_mode = 3;
          end
          m_pos++;
        end
      end
      default: begin
        m_pv = 1'b1; m_ce = m_err; m_dst = '1;
        m_mode = v ? 1 : 0;
      end
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(rf_data_valid, rf_data_in);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        chk("debug_state", debug_state, m_state_code());
        chk("packet_valid", packet_valid, m_pv);
        chk("crc_error", crc_error, m_ce);
        chk("packet_type", packet_type, m_ptype);
        chk("payload_length", payload_length, m_plen);
        chk("src_addr", src_addr, m_src);
        chk("dst_addr", dst_addr, m_dst);
        chk("payload_data", payload_data, m_pay);
        chk("debug_rssi", debug_rssi, m_rssi);
        if (debug_state == 8'd4) saw_pay = 1'b1;
      end
    end
  end

  // Inputs change 1 ns after each rising edge and are sampled on the next one
  task automatic step(input logic v, input logic d);
    rf_data_valid = v;
    rf_data_in    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic send_bit(input logic b);
    repeat (OSR) step(1'b1, b);
  endtask

  task automatic preamble(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, i[0]);
  endtask

  task automatic send_aa();
    for (int i = 0; i < 32; i++) send_bit(ACCESS_ADDR[i]);
  endtask

  // crc_sel: 0 correct CRC, 1 all-zero CRC, 2 random CRC; abort_at < 0 sends everything
  task automatic send_body(input logic [7:0] hdr, input logic [47:0] src,
                           input logic [255:0] pay, input int crc_sel, input int abort_at);
    logic        bits[$];
    logic [23:0] c;
    int          n;
    for (int i = 0; i < 8; i++)  bits.push_back(hdr[i]);
    for (int i = 0; i < 48; i++) bits.push_back(src[i]);
    n = int'(hdr[4:0]) * 8;
    for (int i = 0; i < n; i++)  bits.push_back(pay[i]);
    c = CRC_INIT;
    foreach (bits[k]) c = tb_crc(c, bits[k]);
    for (int j = 0; j < 24; j++) begin
      if (crc_sel == 0)      bits.push_back(c[23 - j]);
      else if (crc_sel == 1) bits.push_back(1'b0);
      else                   bits.push_back(1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < bits.size(); k++) begin
      if (k == abort_at) begin
        step(1'b0, 1'b0);
        return;
      end
      send_bit(bits[k]);
    end
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [47:0] src,
                          input logic [255:0] pay, input int crc_sel, input int abort_at);
    preamble(16);
    send_aa();
    send_body(hdr, src, pay, crc_sel, abort_at);
  endtask

  initial begin
    logic [7:0]   r_hdr;
    logic [47:0]  r_src;
    logic [255:0] r_pay;
    int           r_abort;

    rst_n = 1'b0; rf_data_valid = 1'b0; rf_data_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_on = 1'b1;
    rst_n  = 1'b1;
    idle(3);

    // Reset state
    chk("rst packet_valid", packet_valid, 1'b0);
    chk("rst crc_error", crc_error, 1'b0);
    chk("rst debug_state", debug_state, 8'd0);
    chk("rst src_addr", src_addr, 48'h0);
    chk("rst dst_addr", dst_addr, 48'h0);
    chk("rst packet_type", packet_type, 8'h00);
    chk("rst payload_data", payload_data, 256'h0);
    chk("rst debug_rssi", debug_rssi, 16'h0000);

    // Stream without an access address
    for (int i = 0; i < 200; i++) send_bit(i[0]);
    chk("noaa debug_state", debug_state, 8'd1);
    chk("noaa packet_valid", packet_valid, 1'b0);
    idle(3);

    // Directed packet with all-zero CRC
    send_pkt(8'h42, 48'hBC9A78563412, 256'hADDE, 1, -1);
    idle(100);
    chk("p2 packet_valid", packet_valid, 1'b1);
    chk("p2 packet_type", packet_type, 8'h42);
    chk("p2 payload_length", payload_length, 8'd2);
    chk("p2 src_addr", src_addr, 48'hBC9A78563412);
    chk("p2 payload_data", payload_data, 256'hADDE);
    chk("p2 dst_addr", dst_addr, 48'hFFFFFFFFFFFF);
    chk("p2 crc_error", crc_error, 1'b1);
    chk("p2 debug_state", debug_state, 8'd0);

    // Same packet, correct CRC
    send_pkt(8'h42, 48'hBC9A78563412, 256'hADDE, 0, -1);
    idle(5);
    chk("p3 crc_error", crc_error, 1'b0);
    chk("p3 packet_valid", packet_valid, 1'b1);

    // Zero-length payload
    saw_pay = 1'b0;
    send_pkt(8'h40, 48'h0A0B0C0D0E0F, 256'h0, 0, -1);
    idle(5);
    chk("p4 packet_valid", packet_valid, 1'b1);
    chk("p4 crc_error", crc_error, 1'b0);
    chk("p4 payload_length", payload_length, 8'd0);
    chk("p4 payload_data", payload_data, 256'h0);
    chk("p4 pay_state_seen", saw_pay, 1'b0);

    // Abort in the middle of the address field, then a clean packet
    send_pkt(8'h43, 48'h111111111111, 256'h0, 0, 30);
    chk("p5 abort debug_state", debug_state, 8'd0);
    idle(4);
    chk("p5 abort packet_valid", packet_valid, 1'b0);
    send_pkt(8'h41, 48'h665544332211, 256'h77, 0, -1);
    idle(5);
    chk("p5 packet_valid", packet_valid, 1'b1);
    chk("p5 src_addr", src_addr, 48'h665544332211);
    chk("p5 payload_data", payload_data, 256'h77);

    // Back-to-back packets with valid held high
    send_pkt(8'h42, 48'hA1A2A3A4A5A6, 256'hBEEF, 0, -1);
    preamble(16);
    send_aa();
    chk("p6 hit debug_state", debug_state, 8'd2);
    chk("p6 hit packet_valid", packet_valid, 1'b0);
    send_body(8'h43, 48'hB1B2B3B4B5B6, 256'hC0FFEE, 0, -1);
    idle(5);
    chk("p6 packet_valid", packet_valid, 1'b1);
    chk("p6 payload_data", payload_data, 256'hC0FFEE);

    // Randomized packets, CRCs, aborts and gaps
    for (int it = 0; it < 40; it++) begin
      r_hdr = 8'($urandom);
      r_src[31:0]  = $urandom;
      r_src[47:32] = 16'($urandom);
      for (int w = 0; w < 8; w++) r_pay[32*w +: 32] = $urandom;
      r_abort = ($urandom_range(0, 3) == 0) ?
                $urandom_range(0, 79 + 8 * int'(r_hdr[4:0])) : -1;
      preamble(2 * $urandom_range(0, 10));
      send_aa();
      send_body(r_hdr, r_src, r_pay, $urandom_range(0, 2), r_abort);
      idle($urandom_range(0, 3));
    end
    idle(3);

    // Reset in the middle of a packet
    preamble(16);
    send_aa();
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
    rst_n = 1'b0;
    #1;
    chk("midrst debug_state", debug_state, 8'd0);
    chk("midrst packet_type", packet_type, 8'h00);
    chk("midrst debug_rssi", debug_rssi, 16'h0000);
    chk("midrst packet_valid", packet_valid, 1'b0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    send_pkt(8'h41, 48'hCAFEF00D1234, 256'h5A, 0, -1);
    idle(5);
    chk("post packet_valid", packet_valid, 1'b1);
    chk("post crc_error", crc_error, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
